truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_seq_pkg.sv | 17 +
 rtl/truth_table_sequencer_if.sv | 31 +++
 rtl/settle_timer.sv | 43 ++++
 rtl/truth_table_sequencer.sv | 110 +++++++++++
 tb/tb_truth_table_sequencer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/truth_seq_pkg.sv
// Shared types and sizes for the truth-table sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package truth_seq_pkg;

    localparam int NUM_VEC = 4;   // minterms of a 2-input function
    localparam int IDX_W   = 2;   // minterm index width
    localparam int CNT_W   = 4;   // settle counter width, covers SETTLE up to 15

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Bundles the sweep request, DUT-under-test responses and captured results.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level request that is only honoured while idle.
interface truth_table_sequencer_if;
    import truth_seq_pkg::*;

    logic               start;
    logic               res_a;
    logic               res_b;
    logic               x;
    logic               y;
    logic               busy;
    logic               done;
    logic [NUM_VEC-1:0] table_a;
    logic [NUM_VEC-1:0] table_b;
    logic [NUM_VEC-1:0] err_mask;
    logic               mismatch;

    // Environment side: requests sweeps and returns the two implementations' outputs.
    modport master (
        output start, res_a, res_b,
        input  x, y, busy, done, table_a, table_b, err_mask, mismatch
    );

    // Sequencer side.
    modport slave (
        input  start, res_a, res_b,
        output x, y, busy, done, table_a, table_b, err_mask, mismatch
    );

endinterface

// File: rtl/settle_timer.sv
// Counts cycles spent driving a vector; flags the last settle cycle.
// Latency: expired_o is combinational on the counter, asserted in the SETTLE-th enabled cycle.
// Backpressure: none; clr_i has priority over en_i.
module settle_timer
    import truth_seq_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter starts at 0, so the SETTLE-th enabled cycle sees SETTLE-1.
    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all four minterms into two implementations of a 2-input function and captures/compares their outputs.
// Latency: done pulses 4*(SETTLE+1) edges after the edge that accepts start.
// Backpressure: start is ignored while busy; results hold in IDLE until the next accepted start.
module truth_table_sequencer
    import truth_seq_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    truth_table_sequencer_if.slave  tts
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_VEC-1:0] ta_q, ta_d;
    logic [NUM_VEC-1:0] tb_q, tb_d;
    logic [NUM_VEC-1:0] em_q, em_d;
    logic               timer_clr;
    logic               timer_en;
    logic               timer_exp;
    logic               drive_phase;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_exp)
    );

    // Next-state, index and capture logic; res_a/res_b only ever feed capture bits.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ta_d      = ta_q;
        tb_d      = tb_q;
        em_d      = em_q;
        timer_clr = 1'b1;
        timer_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tts.start) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    ta_d    = '0;
                    tb_d    = '0;
                    em_d    = '0;
                end
            end
            ST_DRIVE: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                if (timer_exp) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                ta_d[idx_q] = tts.res_a;
                tb_d[idx_q] = tts.res_b;
                em_d[idx_q] = tts.res_a ^ tts.res_b;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                    idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, index and result registers; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ta_q    <= '0;
            tb_q    <= '0;
            em_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ta_q    <= ta_d;
            tb_q    <= tb_d;
            em_q    <= em_d;
        end
    end

    // Operands follow the index while a vector is applied, and rest at 0 otherwise.
    assign drive_phase  = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign tts.x        = drive_phase & idx_q[1];
    assign tts.y        = drive_phase & idx_q[0];
    assign tts.busy     = (state_q != ST_IDLE);
    assign tts.done     = (state_q == ST_DONE);
    assign tts.table_a  = ta_q;
    assign tts.table_b  = tb_q;
    assign tts.err_mask = em_q;
    assign tts.mismatch = |em_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE=1 and SETTLE=3) driven by directed sweeps.
// Expected results and done cycles are queued at stimulus time and checked by monitors on done.
// The function under test is a'+b' (NAND built from NOR gates): minterms 0..2 -> 1, minterm 3 -> 0.
module tb_truth_table_sequencer;
    import truth_seq_pkg::*;

    typedef struct {
        logic [3:0] ta;
        logic [3:0] tb;
        logic [3:0] em;
        logic       mm;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic mode1;      // 0: both implementations correct, 1: res_b stuck at 0
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sequencer_if if1();
    truth_table_sequencer_if if3();

    truth_table_sequencer #(.SETTLE(1)) dut1 (.clk(clk), .reset(reset), .tts(if1));
    truth_table_sequencer #(.SETTLE(3)) dut3 (.clk(clk), .reset(reset), .tts(if3));

    assign if1.res_a = ~(if1.x & if1.y);
    assign if1.res_b = mode1 ? 1'b0 : ~(if1.x & if1.y);
    assign if3.res_a = ~(if3.x & if3.y);
    assign if3.res_b = ~(if3.x & if3.y);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue a one-cycle start on dut1 and queue its expected outcome.
    task automatic go1(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] em,
                       input logic mm, input bit push);
        exp_t e;
        e.ta = ta; e.tb = tb; e.em = em; e.mm = mm;
        e.at = cyc + 1 + 4 * (1 + 1);
        if (push) q1.push_back(e);
        if1.start = 1'b1;
        tick(1);
        if1.start = 1'b0;
    endtask

    task automatic chk_zero(input string tag, input logic [1:0] xy, input logic busy,
                            input logic done, input logic [3:0] ta, input logic [3:0] tb,
                            input logic [3:0] em, input logic mm);
        chk({tag, " xy"}, xy, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " table_a"}, ta, 0);
        chk({tag, " table_b"}, tb, 0);
        chk({tag, " err_mask"}, em, 0);
        chk({tag, " mismatch"}, mm, 0);
    endtask

    // dut1 monitor: every done cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (if1.done === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1 spurious done", if1.done, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1 done cycle", cyc, e.at);
                chk("dut1 table_a", if1.table_a, e.ta);
                chk("dut1 table_b", if1.table_b, e.tb);
                chk("dut1 err_mask", if1.err_mask, e.em);
                chk("dut1 mismatch", if1.mismatch, e.mm);
            end
        end
    end

    // dut3 monitor.
    always @(negedge clk) begin
        if (if3.done === 1'b1) begin
            if (q3.size() == 0) begin
                chk("dut3 spurious done", if3.done, 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("dut3 done cycle", cyc, e.at);
                chk("dut3 table_a", if3.table_a, e.ta);
                chk("dut3 table_b", if3.table_b, e.tb);
                chk("dut3 err_mask", if3.err_mask, e.em);
                chk("dut3 mismatch", if3.mismatch, e.mm);
            end
        end
    end

    initial begin
        int c;
        exp_t e;
        reset     = 1'b1;
        mode1     = 1'b0;
        if1.start = 1'b0;
        if3.start = 1'b0;
        tick(3);
        chk_zero("reset dut1", {if1.x, if1.y}, if1.busy, if1.done, if1.table_a,
                 if1.table_b, if1.err_mask, if1.mismatch);
        chk_zero("reset dut3", {if3.x, if3.y}, if3.busy, if3.done, if3.table_a,
                 if3.table_b, if3.err_mask, if3.mismatch);
        reset = 1'b0;
        tick(2);

        // Both implementations agree.
        go1(4'b0111, 4'b0111, 4'b0000, 1'b0, 1'b1);
        tick(12);
        chk("hold table_a in idle", if1.table_a, 4'b0111);
        chk("hold busy in idle", if1.busy, 0);

        // res_b stuck at 0.
        mode1 = 1'b1;
        go1(4'b0111, 4'b0000, 4'b0111, 1'b1, 1'b1);
        tick(12);
        chk("hold mismatch in idle", if1.mismatch, 1);

        // Extra start pulse in the third cycle of a sweep must be ignored.
        mode1 = 1'b0;
        go1(4'b0111, 4'b0111, 4'b0000, 1'b0, 1'b1);
        tick(2);
        if1.start = 1'b1;
        tick(1);
        if1.start = 1'b0;
        tick(12);

        // Reset while minterm 2 is being driven.
        mode1 = 1'b1;
        go1(4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        tick(4);
        chk("idx2 before reset xy", {if1.x, if1.y}, 2'b10);
        chk("partial err_mask before reset", if1.err_mask, 4'b0011);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_zero("mid-sweep reset", {if1.x, if1.y}, if1.busy, if1.done, if1.table_a,
                 if1.table_b, if1.err_mask, if1.mismatch);
        go1(4'b0111, 4'b0000, 4'b0111, 1'b1, 1'b1);
        tick(12);

        // start held for 20 cycles: two back-to-back sweeps.
        mode1 = 1'b0;
        c = cyc;
        e.ta = 4'b0111; e.tb = 4'b0111; e.em = 4'b0000; e.mm = 1'b0;
        e.at = c + 9;  q1.push_back(e);
        e.at = c + 19; q1.push_back(e);
        if1.start = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            tick(1);
            chk($sformatf("held-start busy k=%0d", k), if1.busy,
                ((k >= 1 && k <= 9) || (k >= 11 && k <= 19)) ? 1 : 0);
            if (k == 20) if1.start = 1'b0;
        end
        tick(3);

        // SETTLE=3: operands step 00,01,10,11, each for 4 cycles, then rest at 00.
        c = cyc;
        e.ta = 4'b0111; e.tb = 4'b0111; e.em = 4'b0000; e.mm = 1'b0;
        e.at = c + 1 + 16;
        q3.push_back(e);
        if3.start = 1'b1;
        tick(1);
        if3.start = 1'b0;
        for (int j = 0; j <= 17; j++) begin
            chk($sformatf("settle3 xy j=%0d", j), {if3.x, if3.y}, (j < 16) ? (j / 4) : 0);
            tick(1);
        end

        tick(5);
        chk("dut1 pending dones", q1.size(), 0);
        chk("dut3 pending dones", q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
